// File: rtl/pipeline_division_ext.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_division_ext
//  Description : Fully pipelined restoring integer divider with valid/ready
//                flow control. Supports per-operation signed or unsigned
//                mode, BITS_PER_STAGE quotient bits per stage, divide-by-zero
//                and signed-overflow flags, and a sideband tag that travels
//                with each result.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_division_ext #(
  parameter int DIVINDED_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DIVINDED_WIDTH-1:0] divinded_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  input  logic                      signed_i,
  input  logic [TAG_WIDTH-1:0]      tag_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [DIVINDED_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  reminder_o,
  output logic                      div_by_zero_o,
  output logic                      overflow_o,
  output logic [TAG_WIDTH-1:0]      tag_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int DW    = DIVINDED_WIDTH;
  localparam int VW    = DIVISOR_WIDTH;
  localparam int ITER  = DW / BITS_PER_STAGE;
  localparam int DEPTH = ITER + 2;
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

  // Stage valid bits: index 0 = input stage, 1..ITER = iteration stages,
  // DEPTH-1 = output stage.
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] en;

  // Per-stage payload, index 0 = input stage, 1..ITER = iteration stages.
  // dvd holds the unconsumed dividend bits in its MSBs and collects the
  // quotient bits in its LSBs, so after ITER stages it is the quotient.
  logic [VW-1:0]        rem_q  [0:ITER];
  logic [DW-1:0]        dvd_q  [0:ITER];
  logic [VW-1:0]        dvs_q  [0:ITER];
  logic                 qneg_q [0:ITER];
  logic                 rneg_q [0:ITER];
  logic                 dz_q   [0:ITER];
  logic                 ovf_q  [0:ITER];
  logic [TAG_WIDTH-1:0] tag_q  [0:ITER];

  logic [VW-1:0] rem_d [1:ITER];
  logic [DW-1:0] dvd_d [1:ITER];

  // Input-stage next values
  logic          dvd_neg;
  logic          dvs_neg;
  logic          s0_dz_d;
  logic          s0_ovf_d;
  logic [DW-1:0] s0_dvd_d;
  logic [VW-1:0] s0_dvs_d;
  logic          s0_qneg_d;
  logic          s0_rneg_d;

  // Output-stage next values and registers
  logic [DW-1:0]        quot_d;
  logic [VW-1:0]        remo_d;
  logic [DW-1:0]        quotient_q;
  logic [VW-1:0]        reminder_q;
  logic                 dz_out_q;
  logic                 ovf_out_q;
  logic [TAG_WIDTH-1:0] tag_out_q;

  // Per-stage enables: a stage may load when it is empty or its successor loads.
  always_comb begin : p_enable
    logic acc;
    en  = '0;
    acc = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc   = acc | ~valid_q[k];
      en[k] = acc;
    end
  end

  assign ready_o = en[0] & ~rst_i;

  // Input stage: sign extraction, special-case detection and magnitude conversion.
  // On divide-by-zero the raw dividend is passed unsigned, so the restoring
  // steps naturally yield an all-ones quotient and the dividend's low bits
  // as remainder.
  always_comb begin
    dvd_neg   = signed_i & divinded_i[DW-1];
    dvs_neg   = signed_i & divisor_i[VW-1];
    s0_dz_d   = (divisor_i == '0);
    s0_ovf_d  = signed_i & (divinded_i == Q_MIN) & (divisor_i == '1);
    s0_dvd_d  = (dvd_neg & ~s0_dz_d) ? -divinded_i : divinded_i;
    s0_dvs_d  = dvs_neg ? -divisor_i : divisor_i;
    s0_qneg_d = (dvd_neg ^ dvs_neg) & ~s0_dz_d;
    s0_rneg_d = dvd_neg & ~s0_dz_d;
  end

  // Iteration stages: BITS_PER_STAGE restoring shift-subtract steps, MSB first.
  always_comb begin : p_iter
    logic [VW:0]   t;
    logic [VW-1:0] rem;
    logic [DW-1:0] dvd;
    t   = '0;
    rem = '0;
    dvd = '0;
    for (int k = 1; k <= ITER; k++) begin
      rem = rem_q[k-1];
      dvd = dvd_q[k-1];
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        t   = {rem, dvd[DW-1]};
        dvd = dvd << 1;
        if (t >= {1'b0, dvs_q[k-1]}) begin
          t      = t - {1'b0, dvs_q[k-1]};
          dvd[0] = 1'b1;
        end
        rem = t[VW-1:0];
      end
      rem_d[k] = rem;
      dvd_d[k] = dvd;
    end
  end

  // Stage valid bits advance with their enables; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (en[0]) valid_q[0] <= valid_i;
      for (int k = 1; k < DEPTH; k++) begin
        if (en[k]) valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // Datapath payload; qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (en[0]) begin
      rem_q[0]  <= '0;
      dvd_q[0]  <= s0_dvd_d;
      dvs_q[0]  <= s0_dvs_d;
      qneg_q[0] <= s0_qneg_d;
      rneg_q[0] <= s0_rneg_d;
      dz_q[0]   <= s0_dz_d;
      ovf_q[0]  <= s0_ovf_d;
      tag_q[0]  <= tag_i;
    end
    for (int k = 1; k <= ITER; k++) begin
      if (en[k]) begin
        rem_q[k]  <= rem_d[k];
        dvd_q[k]  <= dvd_d[k];
        dvs_q[k]  <= dvs_q[k-1];
        qneg_q[k] <= qneg_q[k-1];
        rneg_q[k] <= rneg_q[k-1];
        dz_q[k]   <= dz_q[k-1];
        ovf_q[k]  <= ovf_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
    end
  end

  // Output stage: restore signs, then force the signed-overflow result.
  always_comb begin
    quot_d = qneg_q[ITER] ? -dvd_q[ITER] : dvd_q[ITER];
    remo_d = rneg_q[ITER] ? -rem_q[ITER] : rem_q[ITER];
    if (ovf_q[ITER]) begin
      quot_d = Q_MIN;
      remo_d = '0;
    end
  end

  // Output registers; they hold while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quotient_q <= '0;
      reminder_q <= '0;
      dz_out_q   <= 1'b0;
      ovf_out_q  <= 1'b0;
      tag_out_q  <= '0;
    end else if (en[DEPTH-1]) begin
      quotient_q <= quot_d;
      reminder_q <= remo_d;
      dz_out_q   <= dz_q[ITER];
      ovf_out_q  <= ovf_q[ITER];
      tag_out_q  <= tag_q[ITER];
    end
  end

  assign quotient_o    = quotient_q;
  assign reminder_o    = reminder_q;
  assign div_by_zero_o = dz_out_q;
  assign overflow_o    = ovf_out_q;
  assign tag_o         = tag_out_q;
  assign valid_o       = valid_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_division_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_division_ext
//  Description : Self-checking bench for pipeline_division_ext with a
//                queue-based arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_division_ext;

  localparam int DW    = 8;
  localparam int VW    = 8;
  localparam int BPS   = 1;
  localparam int TW    = 4;
  localparam int ITER  = DW / BPS;
  localparam int DEPTH = ITER + 2;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] divinded_i;
  logic [VW-1:0] divisor_i;
  logic          signed_i;
  logic [TW-1:0] tag_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] quotient_o;
  logic [VW-1:0] reminder_o;
  logic          div_by_zero_o;
  logic          overflow_o;
  logic [TW-1:0] tag_o;
  logic          valid_o;
  logic          ready_i;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  pipeline_division_ext #(
    .DIVINDED_WIDTH(DW),
    .DIVISOR_WIDTH (VW),
    .BITS_PER_STAGE(BPS),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .divinded_i   (divinded_i),
    .divisor_i    (divisor_i),
    .signed_i     (signed_i),
    .tag_i        (tag_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .quotient_o   (quotient_o),
    .reminder_o   (reminder_o),
    .div_by_zero_o(div_by_zero_o),
    .overflow_o   (overflow_o),
    .tag_o        (tag_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, truncating toward zero.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                 input logic s, input logic [TW-1:0] t);
    exp_t   e;
    longint sa;
    longint sb;
    e.tag = t;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    e.q   = '0;
    e.r   = '0;
    if (b == '0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = a[VW-1:0];
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      if (s && sa == -(longint'(1) << (DW - 1)) && sb == -1) begin
        e.ovf = 1'b1;
        e.q   = {1'b1, {(DW-1){1'b0}}};
        e.r   = '0;
      end else begin
        e.q = DW'(sa / sb);
        e.r = VW'(sa % sb);
      end
    end
    return e;
  endfunction

  // Scoreboard: inputs and outputs change only just after rising edges,
  // so mid-cycle values decide the handshakes of the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_result", 32'(valid_o), 32'd0);
        end else begin
          mon_e = exp_q[0];
          check_val("quotient", 32'(quotient_o), 32'(mon_e.q));
          check_val("remainder", 32'(reminder_o), 32'(mon_e.r));
          check_val("flags", {30'd0, div_by_zero_o, overflow_o}, {30'd0, mon_e.dz, mon_e.ovf});
          check_val("tag", 32'(tag_o), 32'(mon_e.tag));
          if (ready_i) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (valid_i && ready_o)
        exp_q.push_back(model(divinded_i, divisor_i, signed_i, tag_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic s, input logic [TW-1:0] t);
    divinded_i = a;
    divisor_i  = b;
    signed_i   = s;
    tag_i      = t;
  endtask

  task automatic rand_op(input logic [TW-1:0] t);
    int            sel;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    sel = $urandom_range(0, 9);
    a   = DW'($urandom);
    b   = VW'($urandom);
    if (sel == 0) b = '0;
    else if (sel == 1) begin a = {1'b1, {(DW-1){1'b0}}}; b = '1; end
    else if (sel == 2) b = '1;
    set_op(a, b, 1'($urandom_range(0, 1)), t);
  endtask

  task automatic drain();
    int cnt;
    valid_i = 1'b0;
    ready_i = 1'b1;
    cnt     = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      step();
      cnt++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // One operation into an empty pipeline; it is presented in cycle 0 and
  // its result must be valid in cycle ITER+2.
  task automatic directed(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er,
                          input logic edz, input logic eovf);
    logic acc;
    int   cyc;
    ready_i = 1'b1;
    set_op(a, b, s, 4'h5);
    valid_i = 1'b1;
    #1 acc = ready_o;
    check_val("dir_accept", 32'(acc), 32'd1);
    step();
    valid_i = 1'b0;
    cyc = 1;
    while (!valid_o && cyc < 40) begin
      step();
      cyc++;
    end
    check_val("dir_latency", 32'(cyc), 32'(DEPTH));
    check_val("dir_quotient", 32'(quotient_o), 32'(eq));
    check_val("dir_remainder", 32'(reminder_o), 32'(er));
    check_val("dir_flags", {30'd0, div_by_zero_o, overflow_o}, {30'd0, edz, eovf});
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   cyc;
    int   out0;
    logic acc;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    set_op('0, '0, 1'b0, '0);
    #2;
    check_val("rst_ready", 32'(ready_o), 32'd0);
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_outputs", {quotient_o, reminder_o, tag_o, div_by_zero_o, overflow_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_val("rst_release_ready", 32'(ready_o), 32'd1);

    // Directed cases
    directed(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0);
    directed(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0);
    directed(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
    directed(8'd37, 8'd0, 1'b0, 8'hFF, 8'h25, 1'b1, 1'b0);
    directed(8'd37, 8'd0, 1'b1, 8'hFF, 8'h25, 1'b1, 1'b0);

    // Backpressure: output stalled for 20 cycles while tags stream in
    out0    = n_out;
    ready_i = 1'b0;
    idx     = 0;
    for (int c = 0; c < 20; c++) begin
      rand_op(TW'(idx));
      valid_i = 1'b1;
      #1 acc = ready_o;
      step();
      if (acc) idx++;
    end
    check_val("bp_accepted", 32'(idx), 32'(DEPTH));
    check_val("bp_ready_low", 32'(ready_o), 32'd0);
    check_val("bp_valid_high", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    cyc = 0;
    while (idx < 16 && cyc < 100) begin
      rand_op(TW'(idx));
      valid_i = 1'b1;
      #1 acc = ready_o;
      step();
      if (acc) idx++;
      cyc++;
    end
    drain();
    check_val("bp_out_count", 32'(n_out - out0), 32'd16);

    // Random soak
    idx = 0;
    cyc = 0;
    while (idx < 10000 && cyc < 60000) begin
      rand_op(TW'($urandom));
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = 1'($urandom_range(0, 1));
      #1 acc = valid_i && ready_o;
      step();
      if (acc) idx++;
      cyc++;
    end
    check_val("soak_accepted", 32'(idx), 32'd10000);
    drain();

    // Reset with five operations in flight
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(8'd50 + 8'(i), 8'd3, 1'b0, TW'(i));
      valid_i = 1'b1;
      step();
    end
    valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(valid_o), 32'd0);
    check_val("mid_rst_ready", 32'(ready_o), 32'd0);
    check_val("mid_rst_outputs", {quotient_o, reminder_o, tag_o, div_by_zero_o, overflow_o}, 32'd0);
    exp_q.delete();
    step();
    step();
    rst  = 1'b0;
    out0 = n_out;
    repeat (20) step();
    check_val("mid_rst_no_leak", 32'(n_out - out0), 32'd0);
    directed(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
